button_ctrl: RTL and testbench
==============================

BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5, number of button channels (legal 1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a new level (legal 2..2^24).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port addr  input  32  bus address from Bridge; only addr[3:2] decoded.
REQ-006 SHALL have port we  input  1  bus write strobe, one cycle per write.
REQ-007 SHALL have port wdata  input  32  bus write data.
REQ-008 SHALL have port button_input  input  NUM_BTN  raw asynchronous board buttons, active-high.
REQ-009 SHALL have port rdata  output  32  registered read data to Bridge.
REQ-010 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-011 SHALL pass each button_input bit through a 2-flop synchronizer before any other logic.
REQ-012 SHALL keep a per-channel debounced level and counter; the counter increments while the synced bit differs from the level and clears when they match.
REQ-013 SHALL flip the debounced level and clear the counter in the cycle the counter reaches DEBOUNCE_CYCLES-1; glitches shorter than that SHALL never change the level.
REQ-014 SHALL raise a one-cycle internal press event on each 0->1 transition of a debounced level.
REQ-015 SHALL map addr[3:2]: 0 = STATE (RO, debounced levels), 1 = PRESS_PEND (sticky press flags, W1C), 2 = IRQ_EN (RW mask), 3 = RELEASE_PEND (see REQ-022).
REQ-016 SHALL update rdata every cycle from the register selected by current addr, giving 1-cycle read latency; bits 31:NUM_BTN SHALL read 0.
REQ-017 SHALL clear PRESS_PEND bit i when we=1, addr[3:2]=1 and wdata[i]=1; writes to STATE SHALL be ignored.
REQ-018 SHALL give a press event priority over a simultaneous W1C on the same bit (bit stays 1).
REQ-019 SHALL drive irq = OR of (PRESS_PEND & IRQ_EN) [OR (RELEASE_PEND & IRQ_EN) when configured], from registered state only, no combinational path from bus inputs.
REQ-020 SHALL allow a pending flag to remain set regardless of IRQ_EN; enabling a mask bit with a flag already set SHALL assert irq in the next cycle.

Reset
REQ-021 SHALL on rst_n=0 immediately clear synchronizers, counters, debounced levels, PRESS_PEND, RELEASE_PEND, IRQ_EN, rdata and irq to 0; a button held through reset release SHALL produce a press event after debounce.

Configuration
REQ-022 SHALL, with macro BUTTON_RELEASE_EVT_EN defined, set RELEASE_PEND bit i on each 1->0 debounced transition, W1C at addr[3:2]=3 with set-wins priority, included in irq.
REQ-023 SHALL, without BUTTON_RELEASE_EVT_EN, read 0 at addr[3:2]=3, ignore writes there, and generate no release events.

Structure
REQ-024 SHALL place register offset constants (STATE, PRESS_PEND, IRQ_EN, RELEASE_PEND) in shared package button_pkg.
REQ-025 SHALL implement synchronizer plus debounce counter in sub-module btn_debounce, one instance per channel via generate, outputs level, rise, fall.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=5)
REQ-026 Reset: rst_n=0 mid-debounce with button_input=5'b00001 -> rdata=0, irq=0 at once; after release, STATE=0x1 after 2+4 cycles.
REQ-027 Glitch: button_input[0] high 3 cycles then low -> STATE stays 0x0, PRESS_PEND stays 0x0.
REQ-028 Press+IRQ: IRQ_EN=0x04, hold bit 2 -> STATE=0x04, PRESS_PEND=0x04, irq=1; write 0x04 to PRESS_PEND -> irq=0 next cycle.
REQ-029 Collision: W1C 0x02 in same cycle as bit-1 press event -> PRESS_PEND bit1 remains 1.
REQ-030 Release (macro on): release held bit 3 -> RELEASE_PEND=0x08; macro off -> addr 0xC reads 0x0 always.
REQ-031 Read latency: addr switches 0x0->0x8 with IRQ_EN=0x1F -> rdata=0x1F exactly one cycle later.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button controller: register map selectors decoded from addr[3:2].
// No timing or flow control lives here; every user imports it.
package button_pkg;

    typedef enum logic [1:0] {
        REG_STATE        = 2'd0,
        REG_PRESS_PEND   = 2'd1,
        REG_IRQ_EN       = 2'd2,
        REG_RELEASE_PEND = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer plus stable-count debounce, with rise/fall pulses.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; backpressure: none, free running.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        flip    = 1'b0;
        // Counter only runs while the synced input disagrees; any agreement restarts it.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                flip    = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = flip & ~level_q;
    assign fall  = flip &  level_q;

endmodule

// File: rtl/button_ctrl.sv
// Debounced button bank with sticky press (and, under BUTTON_RELEASE_EVT_EN, release) flags and masked irq.
// Read data registered, 1-cycle latency; no backpressure, writes are single-cycle strobes.
module button_ctrl
    import button_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    input  logic [NUM_BTN-1:0] button_input,
    output logic [31:0]        rdata,
    output logic               irq
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(button_input[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    reg_sel_e           sel;
    logic [NUM_BTN-1:0] press_pend_q, press_pend_d;
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic [NUM_BTN-1:0] rel_pend;
    logic [31:0]        rdata_q, rdata_d;
    logic [NUM_BTN-1:0] rd_val;

    assign sel = reg_sel_e'(addr[3:2]);

`ifdef BUTTON_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] rel_pend_q, rel_pend_d;

    always_comb begin
        rel_pend_d = rel_pend_q;
        if (we && sel == REG_RELEASE_PEND) begin
            rel_pend_d = rel_pend_q & ~wdata[NUM_BTN-1:0];
        end
        rel_pend_d = rel_pend_d | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_pend_q <= '0;
        end else begin
            rel_pend_q <= rel_pend_d;
        end
    end

    assign rel_pend = rel_pend_q;
`else
    assign rel_pend = '0;
`endif

    always_comb begin
        press_pend_d = press_pend_q;
        if (we && sel == REG_PRESS_PEND) begin
            press_pend_d = press_pend_q & ~wdata[NUM_BTN-1:0];
        end
        // A new press must never be lost to a clear issued in the same cycle.
        press_pend_d = press_pend_d | rise;

        irq_en_d = irq_en_q;
        if (we && sel == REG_IRQ_EN) begin
            irq_en_d = wdata[NUM_BTN-1:0];
        end

        case (sel)
            REG_STATE:      rd_val = level;
            REG_PRESS_PEND: rd_val = press_pend_q;
            REG_IRQ_EN:     rd_val = irq_en_q;
            default:        rd_val = rel_pend;
        endcase
        rdata_d              = '0;
        rdata_d[NUM_BTN-1:0] = rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pend_q <= '0;
            irq_en_q     <= '0;
            rdata_q      <= '0;
        end else begin
            press_pend_q <= press_pend_d;
            irq_en_q     <= irq_en_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    // Built only from flops so bus inputs never reach irq combinationally.
    assign irq   = |((press_pend_q | rel_pend) & irq_en_q);

    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata, fall};

endmodule

// File: tb/tb_button_ctrl.sv
// Directed-vector bench for button_ctrl (NUM_BTN=5, DEBOUNCE_CYCLES=4) with a queue scoreboard.
// Stimulus pushes expected rdata/irq values; a negedge monitor pops and compares one cycle later.
module tb_button_ctrl;

    localparam int NB = 5;
    localparam int DB = 4;
`ifdef BUTTON_RELEASE_EVT_EN
    localparam bit REL_ON = 1'b1;
`else
    localparam bit REL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   addr;
    logic          we;
    logic [31:0]   wdata;
    logic [NB-1:0] button_input;
    logic [31:0]   rdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];
    logic        issue = 1'b0;
    logic        vld_q = 1'b0;

    button_ctrl #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .we          (we),
        .wdata       (wdata),
        .button_input(button_input),
        .rdata       (rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vld_q <= issue;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry is due every cycle the bench flagged a response.
    always @(negedge clk) begin
        if (vld_q) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: response with no expected entry");
            end else begin
                logic [32:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e[32]) check(nm, {31'b0, irq}, e[31:0]);
                else       check(nm, rdata, e[31:0]);
            end
        end
    end

    task automatic push(input bit is_irq, input logic [31:0] exp, input string nm);
        exp_q.push_back({is_irq, exp});
        name_q.push_back(nm);
        issue = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr = a;
        push(1'b0, exp, nm);
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic irq_chk(input bit exp, input string nm);
        push(1'b1, {31'b0, exp}, nm);
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic wr_irq(input logic [31:0] a, input logic [31:0] d, input bit exp, input string nm);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        push(1'b1, {31'b0, exp}, nm);
        @(negedge clk);
        we    = 1'b0;
        issue = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b1;
        addr         = '0;
        we           = 1'b0;
        wdata        = '0;
        button_input = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        rd(32'h0, 32'h0, "idle_state");

        // Press bit 0 with its irq enabled, then reset asynchronously while still held.
        button_input = 5'b00001;
        wr(32'h8, 32'h1);
        cyc(8);
        rd(32'h0, 32'h1, "a_state");
        rd(32'h4, 32'h1, "a_pend");
        irq_chk(1'b1, "a_irq");
        rd(32'h8, 32'h1, "a_en");
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rdata", rdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);
        rd(32'h0, 32'h0, "rst_state_early");
        rd(32'h0, 32'h1, "rst_state_settled");
        rd(32'h8, 32'h0, "rst_en_cleared");
        rd(32'h4, 32'h1, "rst_press_pend");
        irq_chk(1'b0, "irq_masked");
        wr_irq(32'h8, 32'h1, 1'b1, "irq_on_enable");
        rd(32'hC, 32'h0, "rel_none_yet");
        button_input = 5'b00000;
        cyc(8);
        rd(32'h0, 32'h0, "a_released");
        rd(32'hC, REL_ON ? 32'h1 : 32'h0, "rel_bit0");
        wr(32'h4, 32'h1F);
        wr(32'hC, 32'h1F);
        rd(32'h4, 32'h0, "a_pend_clr");
        rd(32'hC, 32'h0, "a_rel_clr");
        wr(32'h8, 32'h0);
        irq_chk(1'b0, "a_irq_off");

        // Glitch of 3 cycles is one short of the debounce window.
        button_input = 5'b00001;
        cyc(3);
        button_input = 5'b00000;
        cyc(8);
        rd(32'h0, 32'h0, "glitch_state");
        rd(32'h4, 32'h0, "glitch_pend");

        // Press bit 2 with irq, clear via W1C, writes to STATE ignored.
        wr(32'h8, 32'h4);
        button_input = 5'b00100;
        cyc(8);
        rd(32'h0, 32'h4, "c_state");
        rd(32'h4, 32'h4, "c_pend");
        irq_chk(1'b1, "c_irq");
        wr_irq(32'h4, 32'h4, 1'b0, "c_irq_w1c");
        rd(32'h4, 32'h0, "c_pend_clr");
        wr(32'h0, 32'h1F);
        rd(32'h0, 32'h4, "state_ro");

        // W1C lands in the exact cycle bit 1's press event fires.
        button_input = 5'b00110;
        cyc(5);
        wr(32'h4, 32'h2);
        rd(32'h4, 32'h2, "collision_set_wins");
        wr(32'h4, 32'h2);
        rd(32'h4, 32'h0, "collision_clr");

        // Release of held bit 3.
        button_input = 5'b01110;
        cyc(8);
        wr(32'h4, 32'h1F);
        rd(32'h4, 32'h0, "e_pend_clr");
        button_input = 5'b00110;
        cyc(8);
        rd(32'h0, 32'h6, "e_state");
        rd(32'hC, REL_ON ? 32'h8 : 32'h0, "rel_bit3");
        wr(32'h8, 32'h8);
        irq_chk(REL_ON, "rel_irq");
        wr_irq(32'hC, 32'h8, 1'b0, "rel_irq_w1c");
        rd(32'hC, 32'h0, "rel_clr3");

        // Read latency and upper-bit masking.
        wr(32'h8, 32'hFFFF_FFFF);
        rd(32'h0, 32'h6, "f_state");
        rd(32'h8, 32'h1F, "latency_irq_en");
        irq_chk(1'b0, "f_irq_idle");

        cyc(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
